// File: rtl/aes_round_iter.sv
// Iterative AES-128 encryption datapath: one full round per clock, ten rounds per block.
// Round keys come from an external key expansion; the cipher key itself seeds the initial AddRoundKey.
module aes_round_iter #(
  parameter int TEXT_WIDTH = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [TEXT_WIDTH-1:0] key_i,
  input  logic [TEXT_WIDTH-1:0] key0_i,
  input  logic [TEXT_WIDTH-1:0] key1_i,
  input  logic [TEXT_WIDTH-1:0] key2_i,
  input  logic [TEXT_WIDTH-1:0] key3_i,
  input  logic [TEXT_WIDTH-1:0] key4_i,
  input  logic [TEXT_WIDTH-1:0] key5_i,
  input  logic [TEXT_WIDTH-1:0] key6_i,
  input  logic [TEXT_WIDTH-1:0] key7_i,
  input  logic [TEXT_WIDTH-1:0] key8_i,
  input  logic [TEXT_WIDTH-1:0] key9_i,
  input  logic [TEXT_WIDTH-1:0] text_i,
  input  logic                  start_i,
  output logic                  ready_o,
  output logic [TEXT_WIDTH-1:0] cipher_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  generate
    if (TEXT_WIDTH != 128 || NUM_ROUNDS != 10) begin : g_param_check
      $error("aes_round_iter supports only TEXT_WIDTH=128 and NUM_ROUNDS=10");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // FIPS-197 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e         fsm_q;
  logic [3:0]   round_cnt;
  logic [127:0] state_r;
  logic [127:0] round_key;
  logic [127:0] shifted;
  logic [127:0] round_out;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows fused: byte (row r, column c) takes the S-box of (r, c+r mod 4).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Round r (round_cnt = r) uses the key expansion output key(r-1).
  always_comb begin
    // NOTE: default first so every path assigns round_key; otherwise a latch is inferred.
    round_key = key9_i;
    case (round_cnt)
      4'd1:    round_key = key0_i;
      4'd2:    round_key = key1_i;
      4'd3:    round_key = key2_i;
      4'd4:    round_key = key3_i;
      4'd5:    round_key = key4_i;
      4'd6:    round_key = key5_i;
      4'd7:    round_key = key6_i;
      4'd8:    round_key = key7_i;
      4'd9:    round_key = key8_i;
      default: round_key = key9_i;
    endcase
  end

  assign shifted   = sub_shift(state_r);
  assign round_out = ((round_cnt == LAST_ROUND) ? shifted : mix_columns(shifted)) ^ round_key;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the 128-bit datapath registers are reset too, so cipher_o reads 0 after reset.
      fsm_q     <= IDLE;
      round_cnt <= '0;
      state_r   <= '0;
      cipher_o  <= '0;
      valid_o   <= 1'b0;
      ready_o   <= 1'b1;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees pre-edge values of the state.
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_r   <= text_i ^ key_i;
            round_cnt <= 4'd1;
            ready_o   <= 1'b0;
            fsm_q     <= RUN;
          end
        end
        RUN: begin
          state_r   <= round_out;
          round_cnt <= round_cnt + 4'd1;
          if (round_cnt == LAST_ROUND) begin
            cipher_o  <= round_out;
            valid_o   <= 1'b1;
            round_cnt <= '0;
            fsm_q     <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            fsm_q   <= IDLE;
          end
        end
        default: begin
          fsm_q   <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
